// File: rtl/oam_dma_ctrl_pkg.sv
// Shared CPU control definitions used by the OAM DMA controller:
// state encoding, default geometry and the echo-RAM page fold.
package oam_dma_ctrl_pkg;

  localparam int         DMA_LEN_DEFAULT  = 160;
  localparam logic [7:0] DST_PAGE_DEFAULT = 8'hFE;
  localparam logic [7:0] ECHO_BASE        = 8'hE0;
  localparam logic [7:0] ECHO_MASK        = 8'hDF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_RD_A = 3'd2,
    ST_RD_B = 3'd3,
    ST_WR_A = 3'd4,
    ST_WR_B = 3'd5,
    ST_FIN  = 3'd6
  } state_e;

  // Pages E0..FF mirror C0..DF, so the DMA always reads the real RAM page.
  function automatic logic [7:0] fold_page(input logic [7:0] page);
    return (page >= ECHO_BASE) ? (page & ECHO_MASK) : page;
  endfunction

endpackage

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: copies DMA_LEN bytes from a source page to DST_PAGE,
// one byte per four cycles, once the CPU grants the shared bus.
module oam_dma_ctrl
  import oam_dma_ctrl_pkg::*;
#(
  parameter int         DMA_LEN  = DMA_LEN_DEFAULT,
  parameter logic [7:0] DST_PAGE = DST_PAGE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trig_wr,
  input  logic [7:0]  trig_data,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] addr,
  output logic        addr_oe,
  output logic        mem_cs,
  output logic        mem_oe,
  output logic        mem_we,
  input  logic [7:0]  rdata,
  output logic [7:0]  wdata,
  output logic        busy,
  output logic        done,
  output state_e      dbg_state
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  state_e     state_q, state_d;
  logic [7:0] src_page_q, src_page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] buf_q, buf_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      src_page_q <= 8'h00;
      idx_q      <= 8'h00;
      buf_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      src_page_q <= src_page_d;
      idx_q      <= idx_d;
      buf_q      <= buf_d;
    end
  end

  // Handshake: bus_req rises in REQ and stays high through WR_B; the CPU
  // raises bus_gnt when it releases the bus and holds it while bus_req is high.
  always_comb begin
    state_d    = state_q;
    src_page_d = src_page_q;
    idx_d      = idx_q;
    buf_d      = buf_q;
    case (state_q)
      ST_IDLE: begin
        if (trig_wr) begin
          src_page_d = fold_page(trig_data);
          idx_d      = 8'h00;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        // A retrigger here only reloads; the bus must still be granted first.
        if (trig_wr) begin
          src_page_d = fold_page(trig_data);
          idx_d      = 8'h00;
        end
        if (bus_gnt) state_d = ST_RD_A;
      end
      ST_RD_A: state_d = ST_RD_B;
      ST_RD_B: begin
        buf_d   = rdata;
        state_d = ST_WR_A;
      end
      ST_WR_A: state_d = ST_WR_B;
      ST_WR_B: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_FIN;
        end else begin
          idx_d   = idx_q + 8'h01;
          state_d = ST_RD_A;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        if (trig_wr) begin
          src_page_d = fold_page(trig_data);
          idx_d      = 8'h00;
          state_d    = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Retrigger while owning the bus restarts at byte 0 without releasing it.
    if (trig_wr && (state_q inside {ST_RD_A, ST_RD_B, ST_WR_A, ST_WR_B})) begin
      src_page_d = fold_page(trig_data);
      idx_d      = 8'h00;
      state_d    = ST_RD_A;
    end
  end

  always_comb begin
    bus_req = 1'b0;
    busy    = (state_q != ST_IDLE);
    done    = 1'b0;
    addr_oe = 1'b0;
    mem_cs  = 1'b0;
    mem_oe  = 1'b0;
    mem_we  = 1'b0;
    addr    = 16'h0000;
    case (state_q)
      ST_REQ: bus_req = 1'b1;
      ST_RD_A, ST_RD_B: begin
        bus_req = 1'b1;
        addr_oe = 1'b1;
        mem_cs  = 1'b1;
        mem_oe  = 1'b1;
        addr    = {src_page_q, idx_q};
      end
      ST_WR_A: begin
        bus_req = 1'b1;
        addr_oe = 1'b1;
        mem_cs  = 1'b1;
        mem_we  = 1'b1;
        addr    = {DST_PAGE, idx_q};
      end
      ST_WR_B: begin
        bus_req = 1'b1;
        addr_oe = 1'b1;
        mem_cs  = 1'b1;
        addr    = {DST_PAGE, idx_q};
      end
      ST_FIN: done = 1'b1;
      default: ;
    endcase
  end

  assign wdata     = buf_q;
  assign dbg_state = state_q;

endmodule
